inst_fetch_buffer: RTL

- Fetch stage directly downstream of the PC register.
- Takes the PC stream (pc_i, ce_i) and issues one instruction-ROM read at a time over a req/ack handshake.
- Stores each returned {pc, inst} pair in a DEPTH-entry FIFO and presents it to the decode stage via valid/ready.
- Back-pressures the PC stage with stall_req_o; discards all fetched and in-flight instructions on flush_i (branch/exception redirect).

---
 rtl/inst_fetch_buffer_if.sv | 29 ++
 rtl/inst_fetch_buffer.sv | 91 +++++++++
 2 files changed

// File: rtl/inst_fetch_buffer_if.sv
// inst_fetch_buffer_if: PC-in, ROM req/ack and decode valid/ready bundle of the fetch buffer.
interface inst_fetch_buffer_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic [AW-1:0] pc_i;
   logic          ce_i;
   logic          stall_req_o;
   logic          flush_i;
   logic          rom_req_o;
   logic [AW-1:0] rom_addr_o;
   logic          rom_ack_i;
   logic [DW-1:0] rom_data_i;
   logic          id_valid_o;
   logic          id_ready_i;
   logic [AW-1:0] id_pc_o;
   logic [DW-1:0] id_inst_o;
   logic [CW-1:0] count_o;
   modport slave (
      input  pc_i, ce_i, flush_i, rom_ack_i, rom_data_i, id_ready_i,
      output stall_req_o, rom_req_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, count_o
   );
   modport master (
      output pc_i, ce_i, flush_i, rom_ack_i, rom_data_i, id_ready_i,
      input  stall_req_o, rom_req_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, count_o
   );
endinterface

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: single-outstanding ROM fetcher feeding a DEPTH-entry {pc, inst} FIFO toward decode.
module inst_fetch_buffer #(
   parameter int DEPTH = 4,
   parameter int AW = 32,
   parameter int DW = 32
) (
   input logic clk,
   input logic rst,
   inst_fetch_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;
   state_e        state_q;
   logic          req_q;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] pc_mem_q [DEPTH];
   logic [DW-1:0] inst_mem_q [DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] hpc_q, hpc_d;
   logic [DW-1:0] hinst_q, hinst_d;
   logic          cap, push, pop, head_new;
   // Space is reserved at issue, so an accepted ack always has a free slot.
   always_comb begin
      cap = state_q == IDLE && bus.ce_i && !bus.flush_i && cnt_q < CW'(DEPTH);
      push = state_q == REQ && bus.rom_ack_i && !bus.flush_i;
      pop = cnt_q != '0 && bus.id_ready_i && !bus.flush_i;
      wp_d = bus.flush_i ? '0 : wp_q + PW'(push);
      rp_d = bus.flush_i ? '0 : rp_q + PW'(pop);
      cnt_d = bus.flush_i ? '0 : cnt_q + CW'(push) - CW'(pop);
      head_new = push && wp_q == rp_d;
      hpc_d = head_new ? addr_q : pc_mem_q[rp_d];
      hinst_d = head_new ? bus.rom_data_i : inst_mem_q[rp_d];
   end
   // An issued request always runs to its ack; DROP only swallows the data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         req_q <= 1'b0;
         addr_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (cap) begin
               state_q <= REQ;
               req_q <= 1'b1;
               addr_q <= bus.pc_i;
            end
            REQ: if (bus.rom_ack_i) begin
               state_q <= IDLE;
               req_q <= 1'b0;
            end else if (bus.flush_i) state_q <= DROP;
            DROP: if (bus.rom_ack_i) begin
               state_q <= IDLE;
               req_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q <= '0;
         rp_q <= '0;
         cnt_q <= '0;
         hpc_q <= '0;
         hinst_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i] <= '0;
            inst_mem_q[i] <= '0;
         end
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
         cnt_q <= cnt_d;
         hpc_q <= hpc_d;
         hinst_q <= hinst_d;
         if (push) begin
            pc_mem_q[wp_q] <= addr_q;
            inst_mem_q[wp_q] <= bus.rom_data_i;
         end
      end
   end
   assign bus.stall_req_o = bus.ce_i & ~cap;
   assign bus.rom_req_o = req_q;
   assign bus.rom_addr_o = addr_q;
   assign bus.id_valid_o = cnt_q != '0;
   assign bus.id_pc_o = hpc_q;
   assign bus.id_inst_o = hinst_q;
   assign bus.count_o = cnt_q;
endmodule
